// File: rtl/aes_key_sched_ctrl_if.sv
// Handshake bundle between the key-schedule controller and its user:
// the start/key request side and the round-key valid/ready stream.
interface aes_key_sched_ctrl_if #(
  parameter int nk = 4
);
  logic              start;
  logic [32*nk-1:0]  key;
  logic              busy;
  logic              rk_valid;
  logic              rk_ready;
  logic [3:0]        rk_round;
  logic [127:0]      rk_data;
  logic              done;

  // Requester / round-key consumer side
  modport master (
    output start, key, rk_ready,
    input  busy, rk_valid, rk_round, rk_data, done
  );

  // Key-schedule controller side
  modport slave (
    input  start, key, rk_ready,
    output busy, rk_valid, rk_round, rk_data, done
  );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES key-schedule controller: one expanded word per cycle from an
// nk-word sliding window, four words assembled into each 128-bit round key,
// round keys handed out over a valid/ready stream. Serves AES-128/192/256.
module aes_key_sched_ctrl #(
  parameter int nk = 4,
  parameter int nr = 10
) (
  input  logic clk,
  input  logic reset,
  aes_key_sched_ctrl_if.slave bus
);
  localparam int last_word = 4 * (nr + 1) - 1;

  // FIPS-197 S-box, byte 0x00 at the MSBs.
  localparam logic [2047:0] sbox_tab = {
    256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return sbox_tab[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_t;

  state_t      state_reg, state_next;
  logic [31:0] window [nk];      // window[0] = w[i-nk], window[nk-1] = w[i-1]
  logic [31:0] slot   [3];       // first three words of the key being assembled
  logic [31:0] key_word [nk];
  logic [5:0]  word_idx;         // i
  logic [2:0]  phase;            // i mod nk
  logic [7:0]  rcon;             // rc for the next i mod nk == 0 word
  logic        busy_reg, valid_reg, done_reg;
  logic [3:0]  round_reg;
  logic [127:0] data_reg;

  logic        accept, advance, load_out, finish;
  logic [31:0] temp, w_new;

  for (genvar gi = 0; gi < nk; gi++) begin : g_key
    assign key_word[gi] = bus.key[32*(nk-gi)-1 -: 32];
  end

  // Next word of the schedule. While i < nk the window simply rotates, so the
  // key words come out in order and the window ends up holding w[0..nk-1].
  always_comb begin
    temp = window[nk-1];
    if (phase == 3'd0)
      temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
    else if (nk == 8 && phase == 3'd4)
      temp = sub_word(temp);
    if (word_idx < 6'(nk))
      w_new = window[0];
    else
      w_new = window[0] ^ temp;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next state and per-cycle control strobes; slot-3 words wait for a free
  // (or simultaneously released) output register.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    advance    = 1'b0;
    load_out   = 1'b0;
    finish     = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = GEN;
        end
      end
      GEN: begin
        if (!(word_idx[1:0] == 2'd3 && valid_reg && !bus.rk_ready)) begin
          advance = 1'b1;
          if (word_idx[1:0] == 2'd3) begin
            load_out = 1'b1;
            if (word_idx == 6'(last_word)) state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (bus.rk_ready) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: window, counters, assembly slots and the output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < nk; j++) window[j] <= '0;
      for (int j = 0; j < 3; j++)  slot[j]   <= '0;
      word_idx  <= '0;
      phase     <= '0;
      rcon      <= 8'h01;
      busy_reg  <= 1'b0;
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
      round_reg <= '0;
      data_reg  <= '0;
    end else begin
      done_reg <= finish;
      if (accept) begin
        for (int j = 0; j < nk; j++) window[j] <= key_word[j];
        word_idx <= '0;
        phase    <= '0;
        rcon     <= 8'h01;
        busy_reg <= 1'b1;
      end else if (advance) begin
        for (int j = 0; j < nk - 1; j++) window[j] <= window[j+1];
        window[nk-1] <= w_new;
        word_idx     <= word_idx + 6'd1;
        phase        <= (phase == 3'(nk - 1)) ? 3'd0 : phase + 3'd1;
        if (phase == 3'd0 && word_idx >= 6'(nk))
          rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        case (word_idx[1:0])
          2'd0:    slot[0] <= w_new;
          2'd1:    slot[1] <= w_new;
          2'd2:    slot[2] <= w_new;
          default: ;
        endcase
      end
      if (load_out) begin
        data_reg  <= {slot[0], slot[1], slot[2], w_new};
        round_reg <= word_idx[5:2];
        valid_reg <= 1'b1;
      end else if (valid_reg && bus.rk_ready) begin
        valid_reg <= 1'b0;
      end
      if (finish) busy_reg <= 1'b0;
    end
  end

  assign bus.busy     = busy_reg;
  assign bus.rk_valid = valid_reg;
  assign bus.rk_round = round_reg;
  assign bus.rk_data  = data_reg;
  assign bus.done     = done_reg;
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: AES-128 and AES-256 instances checked against
// a textbook key-expansion model whose S-box is derived from GF(2^8) inverses.
module tb_aes_key_sched_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  aes_key_sched_ctrl_if #(.nk(4)) ia ();
  aes_key_sched_ctrl_if #(.nk(8)) ib ();

  aes_key_sched_ctrl #(.nk(4), .nr(10)) dut_a (.clk(clk), .reset(reset), .bus(ia));
  aes_key_sched_ctrl #(.nk(8), .nr(14)) dut_b (.clk(clk), .reset(reset), .bus(ib));

  int errors = 0;
  int checks = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] model_a [11];
  logic [127:0] model_b [15];
  int exp_a = 0, exp_b = 0;

  localparam logic [127:0] key128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] key2   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] key256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = (b << n) | (b >> (8 - n));
    return r;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
  endfunction

  // Plain FIPS-197 key expansion into the round-key table of the chosen DUT.
  task automatic build_model(input int nk, input logic [255:0] k);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc [10];
    int nr;
    rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    nr = nk + 6;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) w[i] = k[255 - 32*i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rc[i/nk - 1], 24'h0};
        else if (nk == 8 && i % nk == 4) t = subw(t);
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= nr; r++) begin
      if (nk == 4) model_a[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else         model_b[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  // Compare process: every handshake, every held cycle, every done pulse.
  logic         hold_a = 1'b0, hold_b = 1'b0;
  logic [127:0] prev_data_a, prev_data_b;
  logic [3:0]   prev_round_a, prev_round_b;
  always @(negedge clk) begin
    if (reset) begin
      hold_a = 1'b0;
      hold_b = 1'b0;
    end else begin
      if (hold_a) begin
        check("hold_valid_a", 128'(ia.rk_valid), 128'd1);
        check("hold_round_a", 128'(ia.rk_round), 128'(prev_round_a));
        check("hold_data_a", ia.rk_data, prev_data_a);
      end
      if (hold_b) begin
        check("hold_valid_b", 128'(ib.rk_valid), 128'd1);
        check("hold_round_b", 128'(ib.rk_round), 128'(prev_round_b));
        check("hold_data_b", ib.rk_data, prev_data_b);
      end
      if (ia.rk_valid && ia.rk_ready) begin
        $display("hs a round %0d data %h", ia.rk_round, ia.rk_data);
        if (exp_a <= 10) begin
          check("round_a", 128'(ia.rk_round), 128'(exp_a));
          check("data_a", ia.rk_data, model_a[exp_a]);
        end else check("extra_handshake_a", 128'(exp_a), 128'd10);
        exp_a++;
      end
      if (ib.rk_valid && ib.rk_ready) begin
        $display("hs b round %0d data %h", ib.rk_round, ib.rk_data);
        if (exp_b <= 14) begin
          check("round_b", 128'(ib.rk_round), 128'(exp_b));
          check("data_b", ib.rk_data, model_b[exp_b]);
        end else check("extra_handshake_b", 128'(exp_b), 128'd14);
        exp_b++;
      end
      if (ia.done) begin
        check("done_count_a", 128'(exp_a), 128'd11);
        exp_a = 0;
      end
      if (ib.done) begin
        check("done_count_b", 128'(exp_b), 128'd15);
        exp_b = 0;
      end
      hold_a = ia.rk_valid && !ia.rk_ready;
      hold_b = ib.rk_valid && !ib.rk_ready;
      prev_data_a  = ia.rk_data;
      prev_round_a = ia.rk_round;
      prev_data_b  = ib.rk_data;
      prev_round_b = ib.rk_round;
    end
  end

  // Called at posedge+1; returns at start-accept edge E0 + 1.
  task automatic start_a(input logic [127:0] k);
    build_model(4, {k, 128'h0});
    ia.key = k;
    ia.start = 1'b1;
    @(posedge clk); #1;
    ia.start = 1'b0;
  endtask

  task automatic start_b(input logic [255:0] k);
    build_model(8, k);
    ib.key = k;
    ib.start = 1'b1;
    @(posedge clk); #1;
    ib.start = 1'b0;
  endtask

  task automatic first_valid_a(output int n);
    n = -1;
    for (int c = 1; c <= 50 && n < 0; c++) begin
      @(posedge clk); #1;
      if (ia.rk_valid) n = c;
    end
  endtask

  task automatic wait_round_a(input int r);
    int n = 0;
    while (!(ia.rk_valid && ia.rk_round == 4'(r)) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("timeout_round_a", 128'(ia.rk_valid && ia.rk_round == 4'(r)), 128'd1);
  endtask

  task automatic wait_done_a(input bit rnd);
    int n = 0;
    while (!ia.done && n < 400) begin
      if (rnd) ia.rk_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    check("timeout_done_a", 128'(ia.done), 128'd1);
  endtask

  task automatic wait_done_b(input bit rnd);
    int n = 0;
    while (!ib.done && n < 500) begin
      if (rnd) ib.rk_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    check("timeout_done_b", 128'(ib.done), 128'd1);
  endtask

  initial begin
    int first, dn, ndone;
    ia.start = 1'b0; ia.key = '0; ia.rk_ready = 1'b0;
    ib.start = 1'b0; ib.key = '0; ib.rk_ready = 1'b0;

    // Model pinned to the FIPS-197 vectors
    build_sbox();
    build_model(4, {key128, 128'h0});
    build_model(8, key256);
    check("model_a_r0", model_a[0], key128);
    check("model_a_r1", model_a[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("model_a_r10", model_a[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("model_b_r2", model_b[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
    check("model_b_r14", model_b[14], 128'hfe4890d1e6188d0b046df344706c631e);

    // Reset state
    #12;
    check("rst_busy", 128'(ia.busy), 128'd0);
    check("rst_valid", 128'(ia.rk_valid), 128'd0);
    check("rst_done", 128'(ia.done), 128'd0);
    check("rst_round", 128'(ia.rk_round), 128'd0);
    check("rst_data", ia.rk_data, 128'd0);
    check("rst_valid_b", 128'(ib.rk_valid), 128'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // AES-128 latency with rk_ready held high
    ia.rk_ready = 1'b1;
    start_a(key128);
    check("busy_after_start", 128'(ia.busy), 128'd1);
    first = -1; dn = -1; ndone = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (ia.rk_valid && first < 0) first = n;
      if (ia.done) begin
        ndone++;
        if (dn < 0) dn = n;
      end
    end
    check("first_valid_a", 128'(first), 128'd4);
    check("done_cycle_a", 128'(dn), 128'd45);
    check("done_pulses_a", 128'(ndone), 128'd1);
    check("busy_idle_a", 128'(ia.busy), 128'd0);

    // Backpressure: hold round 3 for ten cycles
    start_a(key128);
    wait_round_a(3);
    ia.rk_ready = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    check("bp_round_held", 128'(ia.rk_round), 128'd3);
    check("bp_busy", 128'(ia.busy), 128'd1);
    ia.rk_ready = 1'b1;
    wait_done_a(1'b0);

    // Random ready, with a start pulse mid-expansion that must be ignored
    start_a(key128);
    for (int n = 0; n < 20; n++) begin
      ia.rk_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    ia.key = {4{32'hffffffff}};
    ia.start = 1'b1;
    @(posedge clk); #1;
    ia.start = 1'b0;
    wait_done_a(1'b1);

    // start on the done cycle
    ia.rk_ready = 1'b1;
    start_a(key2);
    first_valid_a(first);
    check("chain_first_valid", 128'(first), 128'd4);
    wait_done_a(1'b0);
    @(posedge clk); #1;

    // Asynchronous reset during GEN at round 5, then a fresh key
    start_a(key128);
    wait_round_a(5);
    #3;
    reset = 1'b1;
    #1;
    check("arst_busy", 128'(ia.busy), 128'd0);
    check("arst_valid", 128'(ia.rk_valid), 128'd0);
    check("arst_round", 128'(ia.rk_round), 128'd0);
    check("arst_data", ia.rk_data, 128'd0);
    check("arst_done", 128'(ia.done), 128'd0);
    exp_a = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("arst_stays_idle", 128'(ia.rk_valid), 128'd0);
    start_a(key2);
    first_valid_a(first);
    check("arst_new_first_valid", 128'(first), 128'd4);
    wait_done_a(1'b0);

    // AES-256, ready high: latency and done timing
    ib.rk_ready = 1'b1;
    start_b(key256);
    first = -1; dn = -1;
    for (int n = 1; n <= 70; n++) begin
      @(posedge clk); #1;
      if (ib.rk_valid && first < 0) first = n;
      if (ib.done && dn < 0) dn = n;
    end
    check("first_valid_b", 128'(first), 128'd4);
    check("done_cycle_b", 128'(dn), 128'd61);

    // AES-256 with random ready
    start_b(key256);
    wait_done_b(1'b1);
    ib.rk_ready = 1'b1;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
Sequential AES key-schedule controller. It generates round keys one 32-bit word per cycle from a cipher key, using the FIPS-197 recurrence. It emits one 128-bit round key per valid/ready handshake to the round datapath. A single instance serves AES-128, AES-192 or AES-256 by parameter, replacing the fully unrolled combinational expansion with a small iterative engine.

Parameters:
nk, 4, key length in 32-bit words (4, 6 or 8)
nr, 10, number of rounds (10, 12 or 14); (nk, nr) pairs are fixed to (4,10), (6,12), (8,14)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request expansion of key; sampled only in IDLE
key  input  32*nk  cipher key, big-endian word 0 at MSBs; sampled on the start-accept edge only
busy  output  1  high from start-accept until done
rk_valid  output  1  rk_data/rk_round hold a round key
rk_ready  input  1  consumer accepts the round key when rk_valid && rk_ready at a rising edge
rk_round  output  4  round index 0..nr of rk_data
rk_data  output  128  round key words w[4r..4r+3], w[4r] at MSBs
done  output  1  one-cycle pulse after round nr is accepted

Behaviour:
- Reset (async, any time, including mid-expansion): FSM goes to IDLE; busy, rk_valid, done = 0; rk_round = 0; rk_data = 0; word counter and key window cleared. No partial key is emitted after reset.
- FSM states: IDLE, GEN, DRAIN.
  - IDLE: start=1 latches key into an nk-word sliding window, sets counter i=0, busy=1, and goes to GEN. start while busy is ignored.
  - GEN: produces word w[i] in one cycle, then increments i.
    - i < nk: w[i] = key word i.
    - Else temp = w[i-1].
    - If i mod nk == 0: temp = SubWord(RotWord(temp)) ^ Rcon(i/nk). Rcon(j) is {rc_j, 24'h0} with rc = 01,02,04,08,10,20,40,80,1b,36.
    - Else if nk == 8 and i mod nk == 4: temp = SubWord(temp).
    - w[i] = w[i-nk] ^ temp.
  - Each word shifts into the sliding window and into 4-word assembly slot i mod 4.
- On the edge that writes slot 3:
  - If the output register is free (rk_valid == 0), or it is being accepted on that same edge, load rk_data, set rk_round = i/4, and set rk_valid = 1.
  - Otherwise that word is not written; generation stalls with i held. Slots 0..2 of the next key may still fill while the output is held.
- After the word i = 4*(nr+1)-1 is loaded into the output, go to DRAIN.
  - DRAIN waits for the final handshake.
  - On that edge: rk_valid = 0, busy = 0, and done = 1 for exactly one cycle. Return to IDLE.
  - start on the done cycle is accepted; back-to-back expansion is permitted.
- rk_data and rk_round are stable while rk_valid && !rk_ready. rk_valid never drops without a handshake except on reset.
- SubWord: four parallel combinational FIPS-197 S-box lookups. The S-box is local to this block, not shared with the cipher datapath.
- Latency with rk_ready held high:
  - start is accepted at edge E0.
  - Round-0 key is valid after edge E4. Round r is valid after edge E(4r+4).
  - done is high after edge E(4nr+5).
  - nk=4: 44 words, done after E45.
- Words are 32-bit and all XOR is bitwise; no carries. i is wide enough for 4*(nr+1), i.e. 6 bits.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
  - round 0 = key;
  - round 1 = a0fafe1788542cb123a339392a6c7605;
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - rk_valid rises 4 cycles after start; done pulses once, 45 cycles after start.
- AES-256 (nk=8, nr=14), key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - round 2 = 9ba354118e6925afa51a8b5f2067fcde, exercising the Rcon branch at i=8;
  - round 14 = fe4890d1e6188d0b046df344706c631e;
  - i mod 8 == 4 SubWord path is covered.
- AES-128 backpressure: hold rk_ready=0 for 10 cycles while round 3 is valid.
  - rk_data and rk_round stay constant; generation stalls at slot 3 of round 4.
  - After release, rounds 4..10 match the FIPS-197 vectors in order, with no duplicate or skipped round.
- Random rk_ready toggling across the full expansion: consumer sees exactly nr+1 handshakes, rounds 0..nr in order, all matching the reference model.
- Assert reset during GEN at round 5: all outputs go to 0 immediately (async).
  - A new start after reset produces round 0 from the new key.
- start pulsed while busy: ignored, and the current key schedule is uncorrupted.
  - start on the done cycle begins a new expansion, with its round 0 valid 4 cycles later.
